// File: rtl/pwg_pkg.sv
// rtl/pwg_pkg.sv - mode encodings shared by the pulse wave generator
package pwg_pkg;

    localparam int PWG_MODE_W = 2;

    localparam logic [PWG_MODE_W-1:0] PWG_MODE_OFF     = 2'd0;
    localparam logic [PWG_MODE_W-1:0] PWG_MODE_SQUARE  = 2'd1;
    localparam logic [PWG_MODE_W-1:0] PWG_MODE_PULSE   = 2'd2;
    localparam logic [PWG_MODE_W-1:0] PWG_MODE_ONESHOT = 2'd3;

    typedef enum logic [PWG_MODE_W-1:0] {
        OFF     = PWG_MODE_OFF,
        SQUARE  = PWG_MODE_SQUARE,
        PULSE   = PWG_MODE_PULSE,
        ONESHOT = PWG_MODE_ONESHOT
    } pwg_mode_t;

endpackage

// File: rtl/pwg_phase_counter.sv
// rtl/pwg_phase_counter.sv - N-bit phase counter with wrap detect, restart and terminal hold
module pwg_phase_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         restart,
    input  logic         hold,
    input  logic [N-1:0] period,
    output logic [N-1:0] phase,
    output logic [N-1:0] phase_next,
    output logic         at_end
);

    logic [N-1:0] phase_q;
    logic [N-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (ena) begin
            if (restart) begin
                phase_d = '0;
            end else if (hold) begin
                phase_d = phase_q;
            end else if (phase_q == period) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase      = phase_q;
    assign phase_next = phase_d;
    assign at_end     = (phase_q == period);

endmodule

// File: rtl/pulse_wave_generator.sv
// rtl/pulse_wave_generator.sv - shadowed pulse/square/oneshot waveform generator
// Optional cycle_start strobe enabled by defining PWG_CYCLE_STROBE_EN.
module pulse_wave_generator
    import pwg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] period,
    input  logic [N-1:0] duty,
    input  pwg_mode_t    mode,
    input  logic         restart,
    output logic         out,
    output logic [N-1:0] phase,
    output logic         done
`ifdef PWG_CYCLE_STROBE_EN
    ,
    output logic         cycle_start
`endif
);

    logic [N-1:0] period_q, period_d;
    logic [N-1:0] duty_q, duty_d;
    pwg_mode_t    mode_q, mode_d;
    logic         done_q, done_d;
    logic         out_q, out_d;
    logic         hold;
    logic         reload;
    logic         at_end;
    logic [N-1:0] phase_next;

    // Square high time is phase < (period>>1)+1, written as <= to avoid the +1 overflow.
    function automatic logic wave(input pwg_mode_t m, input logic [N-1:0] ph,
                                  input logic [N-1:0] du, input logic [N-1:0] pe);
        logic w;
        case (m)
            SQUARE:         w = (ph <= (pe >> 1));
            PULSE, ONESHOT: w = (ph < du);
            default:        w = 1'b0;
        endcase
        return w;
    endfunction

    pwg_phase_counter #(.N(N)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .restart    (restart),
        .hold       (hold),
        .period     (period_q),
        .phase      (phase),
        .phase_next (phase_next),
        .at_end     (at_end)
    );

    always_comb begin
        hold     = done_q | ((mode_q == ONESHOT) & at_end);
        reload   = ena & (restart | (at_end & ~hold));
        period_d = reload ? period : period_q;
        duty_d   = reload ? duty : duty_q;
        mode_d   = reload ? mode : mode_q;
        done_d   = done_q;
        if (ena) begin
            if (restart) begin
                done_d = 1'b0;
            end else if (hold) begin
                done_d = 1'b1;
            end
        end
        // Registered from next-state values so out never lags phase.
        out_d = ~done_d & wave(mode_d, phase_next, duty_d, period_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            duty_q   <= '0;
            mode_q   <= OFF;
            done_q   <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            duty_q   <= duty_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;

`ifdef PWG_CYCLE_STROBE_EN
    logic cycle_start_q, cycle_start_d;

    always_comb begin
        cycle_start_d = reload;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_start_q <= 1'b0;
        end else begin
            cycle_start_q <= cycle_start_d;
        end
    end

    assign cycle_start = cycle_start_q;
`endif

endmodule

// File: tb/tb_pulse_wave_generator.sv
// tb/tb_pulse_wave_generator.sv - randomized and directed bench against a behavioural model
module tb_pulse_wave_generator;
    import pwg_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic [N-1:0] period;
    logic [N-1:0] duty;
    pwg_mode_t    mode;
    logic         restart;
    logic         out;
    logic [N-1:0] phase;
    logic         done;
`ifdef PWG_CYCLE_STROBE_EN
    logic         cycle_start;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    int m_phase, m_per, m_duty, m_mode, m_done, m_cs;

    pulse_wave_generator #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .period  (period),
        .duty    (duty),
        .mode    (mode),
        .restart (restart),
        .out     (out),
        .phase   (phase),
        .done    (done)
`ifdef PWG_CYCLE_STROBE_EN
        ,
        .cycle_start (cycle_start)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_load();
        m_per  = int'(period);
        m_duty = int'(duty);
        m_mode = int'(mode);
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_per = 0; m_duty = 0; m_mode = 0; m_done = 0; m_cs = 0;
        end else if (ena) begin
            m_cs = 0;
            if (restart) begin
                m_phase = 0; model_load(); m_done = 0; m_cs = 1;
            end else if (m_done == 0) begin
                if (m_phase == m_per) begin
                    if (m_mode == 3) m_done = 1;
                    else begin m_phase = 0; model_load(); m_cs = 1; end
                end else begin
                    m_phase++;
                end
            end
        end else begin
            m_cs = 0;
        end
    endtask

    function automatic int model_out();
        if (m_done != 0) return 0;
        case (m_mode)
            1:       return (m_phase < m_per / 2 + 1) ? 1 : 0;
            2, 3:    return (m_phase < m_duty) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("phase", 32'(phase), 32'(m_phase));
        check("out", 32'(out), 32'(model_out()));
        check("done", 32'(done), 32'(m_done));
`ifdef PWG_CYCLE_STROBE_EN
        check("cycle_start", 32'(cycle_start), 32'(m_cs));
`endif
    endtask

    logic sq_pat [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic os_pat [6] = '{1, 1, 0, 0, 0, 0};

    initial begin
        int hi;
        rst = 1'b1; ena = 1'b0; restart = 1'b0; period = '0; duty = '0; mode = OFF;
        repeat (2) @(posedge clk);
        #1;
        step();
        check("rst_phase", 32'(phase), 0);
        check("rst_out", 32'(out), 0);
        check("rst_done", 32'(done), 0);

        // Square, period 7: first enabled cycle wraps and loads shadows
        mode = SQUARE; period = 8'd7; ena = 1'b1; rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("sq_out", 32'(out), 32'(sq_pat[i % 8]));
            check("sq_phase", 32'(phase), 32'(i % 8));
        end
        repeat (4) step();
        check("sq_mid_phase", 32'(phase), 3);
        rst = 1'b1;
        step();
        check("mid_rst_phase", 32'(phase), 0);
        check("mid_rst_out", 32'(out), 0);
        rst = 1'b0; mode = PULSE; period = 8'd9; duty = 8'd3;
        step();
        check("post_rst_reload_out", 32'(out), 1);

        // Pulse duty change mid-cycle takes effect next cycle only
        hi = int'(out);
        for (int i = 1; i < 10; i++) begin
            if (i == 5) duty = 8'd6;
            step();
            hi += int'(out);
        end
        check("pulse_cur_hi", 32'(hi), 3);
        hi = 0;
        for (int i = 0; i < 10; i++) begin step(); hi += int'(out); end
        check("pulse_next_hi", 32'(hi), 6);

        // Oneshot period 5 duty 2
        rst = 1'b1; step(); rst = 1'b0;
        mode = ONESHOT; period = 8'd5; duty = 8'd2;
        for (int i = 0; i < 10; i++) begin
            step();
            check("os_out", 32'(out), (i < 6) ? 32'(os_pat[i]) : 0);
            check("os_phase", 32'(phase), (i < 5) ? 32'(i) : 5);
            check("os_done", 32'(done), (i >= 6) ? 1 : 0);
        end
        restart = 1'b1; step(); restart = 1'b0;
        check("os_rs_done", 32'(done), 0);
        check("os_rs_phase", 32'(phase), 0);
        check("os_rs_out", 32'(out), 1);
        repeat (8) step();
        check("os_again_done", 32'(done), 1);

        // Pulse with ena toggling; duty above period is constant high
        rst = 1'b1; step(); rst = 1'b0;
        mode = PULSE; period = 8'd4; duty = 8'd5;
        for (int i = 0; i < 12; i++) begin
            ena = (i % 4 == 0) || (i % 4 == 3);
            step();
            check("duty_gt_out", 32'(out), 1);
        end
        ena = 1'b1; duty = 8'd0; restart = 1'b1; step(); restart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("duty0_out", 32'(out), 0);
        end

        // Randomized run
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 99) < 2);
            ena     = ($urandom_range(0, 99) < 80);
            restart = ($urandom_range(0, 99) < 5);
            period  = ($urandom_range(0, 15) == 0) ? N'($urandom) : N'($urandom_range(0, 12));
            duty    = N'($urandom_range(0, 14));
            if ($urandom_range(0, 7) == 0) mode = pwg_mode_t'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_wave_generator.md
PULSE_WAVE_GENERATOR -- requirements
Module: pulse_wave_generator

Interface
REQ-001 Parameter N, default 8, width of period, duty and phase counter.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ena  input  1  advance enable, one counter step per cycle when high.
REQ-005 period  input  N  cycle length minus one (P means P+1 enabled clocks per cycle).
REQ-006 duty  input  N  high-time in enabled clocks for PULSE/ONESHOT modes.
REQ-007 mode  input  2  waveform mode, pwg_pkg::pwg_mode_t.
REQ-008 restart  input  1  force new cycle, sampled only when ena high.
REQ-009 out  output  1  waveform output, registered.
REQ-010 phase  output  N  current counter value, registered.
REQ-011 done  output  1  ONESHOT complete flag, registered.
REQ-012 cycle_start  output  1  one-cycle strobe coincident with phase==0 of each new cycle (present only with PWG_CYCLE_STROBE_EN).

Function
REQ-013 The block SHALL hold shadow registers period_q, duty_q, mode_q, loaded from inputs only at wrap or restart; mid-cycle input changes SHALL have no effect.
REQ-014 With ena low, all registers and outputs SHALL hold, and restart SHALL be ignored.
REQ-015 With ena high and phase==period_q (wrap), phase SHALL go to 0 and shadows SHALL reload; otherwise phase SHALL increment by 1.
REQ-016 restart with ena high SHALL set phase to 0, reload shadows and clear done; restart coincident with wrap SHALL produce the identical result.
REQ-017 out SHALL always equal f(phase, duty_q, period_q, mode_q) for the currently registered values (no lag between out and phase).
REQ-018 OFF: out = 0; phase SHALL keep counting.
REQ-019 SQUARE: out = (phase < (period_q>>1)+1); duty ignored; P=7 gives 4 high / 4 low; P=4 gives 3 high / 2 low; P=0 gives constant high.
REQ-020 PULSE: out = (phase < duty_q); duty_q==0 gives constant low; duty_q > period_q gives constant high.
REQ-021 ONESHOT: as PULSE for one cycle; at the wrap ending that cycle, phase SHALL hold at period_q, out = 0, done = 1, and shadows SHALL NOT reload until restart.
REQ-022 Comparisons SHALL be unsigned N-bit; (period_q>>1)+1 SHALL not overflow for any N.

Reset
REQ-023 rst SHALL dominate ena and restart.
REQ-024 Reset values: phase=0, period_q=0, duty_q=0, mode_q=OFF, out=0, done=0, cycle_start=0.
REQ-025 First enabled cycle after reset SHALL be a wrap (phase==period_q==0) and load the shadows from inputs.
REQ-026 Reset mid-cycle SHALL abandon the cycle with no residual out pulse.

Configuration
REQ-027 Macro PWG_CYCLE_STROBE_EN defined: cycle_start port exists; it is 1 exactly in the cycle after each enabled wrap or restart, else 0.
REQ-028 Macro undefined: no cycle_start port and no associated logic; all other behaviour identical.

Structure
REQ-029 Package pwg_pkg SHALL hold pwg_mode_t {OFF=0, SQUARE=1, PULSE=2, ONESHOT=3} and the mode encoding constants.
REQ-030 Sub-module pwg_phase_counter (N-bit counter with wrap detect, restart, hold-at-terminal) SHALL be used; waveform decode and shadow registers stay in the top.

Verification
REQ-031 N=8, mode=SQUARE, period=7, ena=1 -> out repeats 1,1,1,1,0,0,0,0; phase 0..7 repeating.
REQ-032 PULSE, period=9, duty=3; change duty to 6 mid-cycle -> current cycle 3 high, next cycle 6 high.
REQ-033 ONESHOT, period=5, duty=2 -> out 1,1,0,0,0,0 then 0 forever, phase held at 5, done=1; restart -> done=0, phase=0, pattern repeats once.
REQ-034 PULSE, period=4, ena toggled 1,0,0,1 -> phase advances only on ena-high cycles; duty=0 -> out constant 0; duty=5 -> constant 1.
REQ-035 Running SQUARE period=7 at phase=3, rst pulse -> next cycle phase=0, out=0, mode_q=OFF; first ena cycle reloads shadows.
REQ-036 PWG_CYCLE_STROBE_EN defined, period=3 -> cycle_start high every 4th cycle aligned with phase==0; restart at phase 2 -> strobe next cycle.
